// File: rtl/pool2x2_stream_ctrl.sv
// Frame sequencer for the 2x2 pooling line buffer: latches the per-layer config,
// registers the pixel stream into the line buffer and flags cycles carrying a valid window.
module pool2x2_stream_ctrl #(
    parameter int DW    = 8,
    parameter int DIM_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [2:0]       cfg_sel,
    input  logic             cfg_stride2,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    output logic             s_ready,
    output logic [DW-1:0]    lb_data,
    output logic [2:0]       lb_sel,
    output logic             win_valid,
    output logic             win_last,
    output logic             busy,
    output logic             err_cfg,
    output logic             err_gap
);

    // Handshake: a pixel moves when s_valid & s_ready are both high on a rising edge;
    // s_ready is asserted for exactly the RUN state and never depends on s_valid.
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] width_q, width_d;
    logic [DIM_W-1:0] height_q, height_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [2:0]       sel_q, sel_d;
    logic             stride2_q, stride2_d;
    logic [DW-1:0]    lb_data_q, lb_data_d;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic             l1_q, l1_d, l2_q, l2_d;
    logic             err_cfg_q, err_cfg_d;
    logic             err_gap_q, err_gap_d;

    logic run, hs, legal, col_end, row_end, qualify;

    always_comb begin
        run     = (state_q == RUN);
        hs      = run & s_valid;
        legal   = (cfg_width >= DIM_W'(2)) && (cfg_height >= DIM_W'(2)) &&
                  (!cfg_stride2 || (!cfg_width[0] && !cfg_height[0]));
        col_end = (col_q == width_q - DIM_W'(1));
        row_end = (row_q == height_q - DIM_W'(1));
        qualify = stride2_q ? (row_q[0] & col_q[0])
                            : ((row_q != '0) && (col_q != '0));
    end

    // busy covers the two-cycle drain of the flag pipeline after the last pixel
    assign busy      = run | l1_q | l2_q;
    assign s_ready   = run;
    assign lb_data   = lb_data_q;
    assign lb_sel    = sel_q;
    assign win_valid = v2_q;
    assign win_last  = l2_q;
    assign err_cfg   = err_cfg_q;
    assign err_gap   = err_gap_q;

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        sel_d     = sel_q;
        stride2_d = stride2_q;
        err_cfg_d = err_cfg_q;
        err_gap_d = err_gap_q;
        lb_data_d = hs ? s_data : '0;
        v1_d      = hs & qualify;
        l1_d      = hs & qualify & col_end & row_end;
        v2_d      = v1_q;
        l2_d      = l1_q;
        case (state_q)
            IDLE: begin
                if (cfg_start && !busy) begin
                    if (legal) begin
                        state_d   = RUN;
                        width_d   = cfg_width;
                        height_d  = cfg_height;
                        sel_d     = cfg_sel;
                        stride2_d = cfg_stride2;
                        col_d     = '0;
                        row_d     = '0;
                        err_cfg_d = 1'b0;
                        err_gap_d = 1'b0;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!s_valid) begin
                    err_gap_d = 1'b1;
                end else if (col_end) begin
                    col_d = '0;
                    if (row_end) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + DIM_W'(1);
                    end
                end else begin
                    col_d = col_q + DIM_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            sel_q     <= '0;
            stride2_q <= 1'b0;
            lb_data_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            l1_q      <= 1'b0;
            l2_q      <= 1'b0;
            err_cfg_q <= 1'b0;
            err_gap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            col_q     <= col_d;
            row_q     <= row_d;
            sel_q     <= sel_d;
            stride2_q <= stride2_d;
            lb_data_q <= lb_data_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            l1_q      <= l1_d;
            l2_q      <= l2_d;
            err_cfg_q <= err_cfg_d;
            err_gap_q <= err_gap_d;
        end
    end

endmodule

// File: tb/tb_pool2x2_stream_ctrl.sv
// Bench for pool2x2_stream_ctrl: drives frames, predicts lb_data and window pulses
// per cycle into queues, and a negedge monitor pops and compares them.
module tb_pool2x2_stream_ctrl;

    localparam int DW    = 8;
    localparam int DIM_W = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_start = 1'b0;
    logic [DIM_W-1:0] cfg_width = '0;
    logic [DIM_W-1:0] cfg_height = '0;
    logic [2:0]       cfg_sel = '0;
    logic             cfg_stride2 = 1'b0;
    logic             s_valid = 1'b0;
    logic [DW-1:0]    s_data = '0;
    logic             s_ready;
    logic [DW-1:0]    lb_data;
    logic [2:0]       lb_sel;
    logic             win_valid, win_last, busy, err_cfg, err_gap;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int win_seen = 0;
    logic [2:0] cur_sel = '0;

    int            win_cyc_q[$];
    logic          win_last_q[$];
    int            lb_cyc_q[$];
    logic [DW-1:0] exp_q[$];

    pool2x2_stream_ctrl #(.DW(DW), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_sel(cfg_sel), .cfg_stride2(cfg_stride2),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .lb_data(lb_data), .lb_sel(lb_sel),
        .win_valid(win_valid), .win_last(win_last),
        .busy(busy), .err_cfg(err_cfg), .err_gap(err_gap)
    );

    // clock / reset / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // scoreboard: pops expected window pulses and lb_data values by cycle
    always @(negedge clk) begin
        if (win_cyc_q.size() > 0 && win_cyc_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL win_missing: expected pulse at cycle %0d, still absent at cycle %0d", win_cyc_q[0], cyc);
            void'(win_cyc_q.pop_front());
            void'(win_last_q.pop_front());
        end
        if (win_valid) begin
            win_seen++;
            checks++;
            if (win_cyc_q.size() == 0 || win_cyc_q[0] != cyc) begin
                errors++;
                $display("FAIL win_unexpected: win_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                void'(win_cyc_q.pop_front());
                if (win_last !== win_last_q.pop_front()) begin
                    errors++;
                    $display("FAIL win_last: cycle %0d actual %b required %b", cyc, win_last, ~win_last);
                end
            end
        end else if (win_last !== 1'b0) begin
            checks++; errors++;
            $display("FAIL win_last_alone: win_last=%b without win_valid at cycle %0d, required 0", win_last, cyc);
        end
        if (lb_cyc_q.size() > 0 && lb_cyc_q[0] == cyc) begin
            void'(lb_cyc_q.pop_front());
            checks++;
            if (lb_data !== exp_q[0]) begin
                errors++;
                $display("FAIL lb_data: cycle %0d actual %0h required %0h", cyc, lb_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drives one start cycle; leaves the bench in the following cycle
    task automatic start_frame(input int w, input int h, input logic s2,
                               input logic [2:0] sel, input logic legal);
        cfg_start   = 1'b1;
        cfg_width   = DIM_W'(w);
        cfg_height  = DIM_W'(h);
        cfg_stride2 = s2;
        cfg_sel     = sel;
        win_seen    = 0;
        step();
        cfg_start = 1'b0;
        checks += 3;
        if (s_ready !== legal) begin
            errors++; $display("FAIL start_ready: actual %b required %b", s_ready, legal);
        end
        if (err_cfg !== !legal) begin
            errors++; $display("FAIL start_err_cfg: actual %b required %b", err_cfg, !legal);
        end
        if (legal) cur_sel = sel;
        if (lb_sel !== cur_sel) begin
            errors++; $display("FAIL start_lb_sel: actual %0d required %0d", lb_sel, cur_sel);
        end
        if (legal) begin
            checks += 2;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL start_busy: actual %b required 1", busy);
            end
            if (err_gap !== 1'b0) begin
                errors++; $display("FAIL start_err_gap: actual %b required 0", err_gap);
            end
        end
    endtask

    // drives n_pix pixels from the first RUN cycle; optional gap before pixel gap_idx
    task automatic drive_pixels(input int w, input int h, input logic s2,
                                input int gap_idx, input int gap_len, input int n_pix);
        int r, c;
        logic q;
        logic [DW-1:0] d;
        for (int p = 0; p < n_pix; p++) begin
            if (p == gap_idx) begin
                for (int g = 0; g < gap_len; g++) begin
                    s_valid = 1'b0;
                    s_data  = DW'($urandom_range(1, 255));
                    lb_cyc_q.push_back(cyc + 1);
                    exp_q.push_back('0);
                    step();
                end
            end
            r = p / w;
            c = p % w;
            d = DW'($urandom_range(1, 255));
            s_valid = 1'b1;
            s_data  = d;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++; $display("FAIL pix_ready: pixel (%0d,%0d) actual %b required 1", r, c, s_ready);
            end
            lb_cyc_q.push_back(cyc + 1);
            exp_q.push_back(d);
            q = s2 ? ((r % 2 == 1) && (c % 2 == 1)) : (r >= 1 && c >= 1);
            if (q) begin
                win_cyc_q.push_back(cyc + 2);
                win_last_q.push_back(r == h - 1 && c == w - 1);
            end
            step();
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    // from cycle T_last+1: checks the drain and the window total
    task automatic check_drain(input int exp_wins);
        checks += 2;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL drain_ready: actual %b required 0", s_ready);
        end
        if (busy !== 1'b1) begin
            errors++; $display("FAIL drain_busy1: actual %b required 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL drain_busy2: actual %b required 1", busy);
        end
        step();
        checks += 3;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL drain_busy3: actual %b required 0", busy);
        end
        if (win_seen != exp_wins) begin
            errors++; $display("FAIL win_count: actual %0d required %0d", win_seen, exp_wins);
        end
        if (win_cyc_q.size() != 0) begin
            errors++; $display("FAIL win_pending: %0d expected pulses not observed", win_cyc_q.size());
        end
    endtask

    task automatic test_reset();
        step();
        checks += 8;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: actual %b required 0", s_ready); end
        if (lb_data !== '0)   begin errors++; $display("FAIL rst_lb_data: actual %0h required 0", lb_data); end
        if (lb_sel !== '0)    begin errors++; $display("FAIL rst_lb_sel: actual %0d required 0", lb_sel); end
        if (win_valid !== 1'b0) begin errors++; $display("FAIL rst_win_valid: actual %b required 0", win_valid); end
        if (win_last !== 1'b0)  begin errors++; $display("FAIL rst_win_last: actual %b required 0", win_last); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: actual %b required 0", busy); end
        if (err_cfg !== 1'b0) begin errors++; $display("FAIL rst_err_cfg: actual %b required 0", err_cfg); end
        if (err_gap !== 1'b0) begin errors++; $display("FAIL rst_err_gap: actual %b required 0", err_gap); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_stride2();
        start_frame(4, 4, 1'b1, 3'd3, 1'b1);
        drive_pixels(4, 4, 1'b1, -1, 0, 16);
        check_drain(4);
        start_frame(6, 2, 1'b1, 3'd4, 1'b1);
        drive_pixels(6, 2, 1'b1, -1, 0, 12);
        check_drain(3);
    endtask

    task automatic test_stride1();
        start_frame(3, 3, 1'b0, 3'd1, 1'b1);
        drive_pixels(3, 3, 1'b0, -1, 0, 9);
        check_drain(4);
        start_frame(5, 2, 1'b0, 3'd6, 1'b1);
        drive_pixels(5, 2, 1'b0, -1, 0, 10);
        check_drain(4);
    endtask

    task automatic test_illegal();
        start_frame(5, 4, 1'b1, 3'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL ill_ready: actual %b required 0", s_ready); end
            if (err_cfg !== 1'b1) begin errors++; $display("FAIL ill_sticky: actual %b required 1", err_cfg); end
            step();
        end
        start_frame(1, 4, 1'b0, 3'd7, 1'b0);
        step();
        start_frame(4, 4, 1'b1, 3'd2, 1'b1);
        drive_pixels(4, 4, 1'b1, -1, 0, 16);
        check_drain(4);
    endtask

    task automatic test_gap();
        start_frame(4, 4, 1'b1, 3'd5, 1'b1);
        drive_pixels(4, 4, 1'b1, 8, 2, 16);
        checks++;
        if (err_gap !== 1'b1) begin errors++; $display("FAIL gap_err: actual %b required 1", err_gap); end
        check_drain(4);
    endtask

    task automatic test_back_to_back();
        cfg_start   = 1'b1;
        cfg_width   = DIM_W'(4);
        cfg_height  = DIM_W'(4);
        cfg_stride2 = 1'b1;
        cfg_sel     = 3'd5;
        win_seen    = 0;
        step();
        checks++;
        if (lb_sel !== 3'd5) begin errors++; $display("FAIL b2b_sel1: actual %0d required 5", lb_sel); end
        cfg_width   = DIM_W'(3);
        cfg_height  = DIM_W'(3);
        cfg_stride2 = 1'b0;
        cfg_sel     = 3'd2;
        drive_pixels(4, 4, 1'b1, -1, 0, 16);
        for (int k = 1; k <= 3; k++) begin
            checks += 2;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_T+%0d: actual %b required 0", k, s_ready); end
            if (lb_sel !== 3'd5) begin errors++; $display("FAIL b2b_hold_sel_T+%0d: actual %0d required 5", k, lb_sel); end
            if (k == 3) begin
                checks += 2;
                if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_T+3: actual %b required 0", busy); end
                if (win_seen != 4) begin errors++; $display("FAIL b2b_count1: actual %0d required 4", win_seen); end
                win_seen = 0;
            end
            step();
        end
        checks += 2;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_T+4: actual %b required 1", s_ready); end
        if (lb_sel !== 3'd2) begin errors++; $display("FAIL b2b_sel2: actual %0d required 2", lb_sel); end
        cfg_start = 1'b0;
        cur_sel   = 3'd2;
        drive_pixels(3, 3, 1'b0, -1, 0, 9);
        check_drain(4);
    endtask

    task automatic test_async_reset();
        start_frame(4, 4, 1'b1, 3'd6, 1'b1);
        drive_pixels(4, 4, 1'b1, -1, 0, 6);
        #2;
        win_cyc_q.delete();
        win_last_q.delete();
        lb_cyc_q.delete();
        exp_q.delete();
        rst = 1'b1;
        #1;
        checks += 5;
        if (lb_data !== '0)   begin errors++; $display("FAIL arst_lb_data: actual %0h required 0", lb_data); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL arst_busy: actual %b required 0", busy); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: actual %b required 0", s_ready); end
        if (lb_sel !== '0)    begin errors++; $display("FAIL arst_lb_sel: actual %0d required 0", lb_sel); end
        if (win_valid !== 1'b0) begin errors++; $display("FAIL arst_win: actual %b required 0", win_valid); end
        cur_sel = '0;
        step();
        step();
        checks++;
        if (win_valid !== 1'b0) begin errors++; $display("FAIL arst_pending_win: actual %b required 0", win_valid); end
        rst = 1'b0;
        step();
        start_frame(4, 4, 1'b1, 3'd1, 1'b1);
        drive_pixels(4, 4, 1'b1, -1, 0, 16);
        check_drain(4);
    endtask

    initial begin
        test_reset();
        test_stride2();
        test_stride1();
        test_illegal();
        test_gap();
        test_back_to_back();
        test_async_reset();
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool2x2_stream_ctrl.md
# pool2x2_stream_ctrl

Frame sequencer for the 2x2 pooling line buffer. It latches a per-layer configuration and feeds the line buffer a gap-checked pixel stream together with its tap-select. It tracks the row and column of every accepted pixel and flags which cycles carry a valid 2x2 window for stride-2 or stride-1 pooling. It sits between the feature-map read DMA and the line buffer / max-compare stage. The line buffer has no enable and shifts every cycle, so this block owns the meaning of every cycle of its input.

## Interface
Parameters:
- DW, 8, pixel width.
- DIM_W, 9, width of frame-dimension and counter fields (max 511).

Ports:
- clk  in  1  clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  start-of-frame strobe; sampled only when busy=0.
- cfg_width  in  DIM_W  columns per row (W).
- cfg_height  in  DIM_W  rows per frame (H).
- cfg_sel  in  3  line-buffer tap select for this W; latched, not decoded.
- cfg_stride2  in  1  1 = stride 2, 0 = stride 1.
- s_valid  in  1  upstream pixel valid.
- s_data  in  DW  upstream pixel.
- s_ready  out  1  high exactly while in RUN.
- lb_data  out  DW  to the line buffer stream input (registered).
- lb_sel  out  3  to the line buffer sel (registered, held for the whole frame).
- win_valid  out  1  line-buffer window output holds a valid 2x2 window this cycle.
- win_last  out  1  with win_valid: last window of the frame.
- busy  out  1  frame in progress or pipeline not yet drained.
- err_cfg  out  1  sticky: illegal config at start; cleared by the next legal start.
- err_gap  out  1  sticky: s_valid low inside a frame; cleared by the next legal start.

## Operation
- FSM states: IDLE, RUN.
- IDLE -> RUN on cfg_start & !busy & legal config.
  - Latch W, H, sel, and stride mode.
  - Clear col, row, err_gap and err_cfg.
- Legal config: W>=2 and H>=2; in stride-2 mode W and H must also be even.
  - Illegal config: set err_cfg, stay in IDLE.
- In RUN, a handshake (s_valid & s_ready) accepts pixel (row, col).
  - col increments; at col=W-1 it wraps to 0 and row increments.
- The handshake on pixel (H-1, W-1) returns the FSM to IDLE.
  - s_ready drops the next cycle.
  - A cfg_start in that same cycle is ignored.
- Window qualifier for the accepted pixel:
  - stride 2: row odd AND col odd.
  - stride 1: row>=1 AND col>=1.
  - Window count: (W/2)*(H/2) for stride 2, (W-1)*(H-1) for stride 1.
- Last window: the one qualified on pixel (H-1, W-1).
- Gap: s_valid=0 in RUN sets err_gap.
  - Counters hold.
  - lb_data is driven 0 for that cycle; the line buffer still shifts.
  - Windows on later pixels are still flagged; the data is known-corrupt and err_gap marks it.
- cfg_* inputs are ignored outside the start cycle. lb_sel changes only on a legal start.

## Timing
- Reset values: state IDLE; s_ready 0, lb_data 0, lb_sel 0, win_valid 0, win_last 0, busy 0, err_cfg 0, err_gap 0; counters 0.
- lb_data is s_data registered: a pixel accepted in cycle T appears on lb_data in T+1.
- The line buffer registers its window, so win_valid and win_last for a pixel accepted in cycle T assert in cycle T+2, through a 2-stage flag pipeline.
- s_ready rises in the cycle after the cfg_start cycle.
- busy is high from the cycle after cfg_start until the cycle of win_last inclusive. It is 0 from T_last+3.
  - A new cfg_start is therefore accepted at T_last+3 at the earliest.
- Reset mid-frame: everything returns to its reset value immediately, including pipelined win_valid; no partial flags leak out.
- No back-pressure is accepted downstream; win_valid is a single-cycle pulse per window.

## Test plan
- Stride 2, W=H=4, continuous s_valid:
  - win_valid pulses at handshake cycles of pixels (1,1), (1,3), (3,1), (3,3), each +2.
  - win_last with the 4th pulse; busy=0 three cycles after the last handshake.
- Stride 1, W=H=3:
  - 4 windows, on pixels (1,1), (1,2), (2,1), (2,2).
  - lb_data equals s_data delayed by 1 for all 9 pixels.
- Illegal config (stride 2, W=5, H=4; and separately W=1):
  - err_cfg=1, s_ready stays 0, no win_valid.
  - A following legal start clears err_cfg.
- Gap: W=H=4 stride 2, s_valid low for 2 cycles at pixel (2,0):
  - err_gap=1; lb_data=0 on those cycles.
  - Still exactly 4 win_valid pulses; row/col tracking unaffected.
- Back-to-back frames: cfg_start held high continuously.
  - The second frame starts exactly at T_last+3; lb_sel switches then.
  - cfg_start in cycles T_last..T_last+2 has no effect.
- Async reset asserted between pixels (1,1) and (1,3) of a W=H=4 stride-2 frame:
  - All outputs go to 0 without waiting for clk; the pending win_valid is suppressed.
  - A fresh start then produces 4 windows.
